// File: rtl/sr_latch_sync.sv
// ============================================================================
// sr_latch_sync
// ----------------------------------------------------------------------------
// Clocked model of a gated SR latch array. Each bit samples EN/S/R on the
// rising edge of clk and updates a registered Q / not_Q pair. There are no
// combinational loops; everything is plain flops.
//
// An S=R=1 command while EN=1 is resolved by INVALID_POLICY:
//   0 = NOR-latch style, Q=0 and not_Q=0
//   1 = hold the previous state
//   2 = set-dominant  (Q=1, not_Q=0)
//   3 = reset-dominant (Q=0, not_Q=1)
//
// Parameters:
//   WIDTH           number of independent SR cells
//   INVALID_POLICY  resolution of S=R=1 (see above)
//
// Ports:
//   clk         in   1      sole clock, rising edge
//   rst_n       in   1      synchronous active-low reset
//   EN          in   WIDTH  per-bit gate, 0 = hold
//   S           in   WIDTH  per-bit set request
//   R           in   WIDTH  per-bit reset request
//   Q           out  WIDTH  registered latch state
//   not_Q       out  WIDTH  registered complement (independent flop)
//   invalid     out  WIDTH  last sampled command was EN=S=R=1
//   err_clr     in   1      synchronous clear of err_sticky
//   err_sticky  out  1      any invalid event since reset/clear
// ============================================================================
module sr_latch_sync #(
    parameter int WIDTH          = 1,
    parameter int INVALID_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] EN,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] not_Q,
    output logic [WIDTH-1:0] invalid,
    input  logic             err_clr,
    output logic             err_sticky
);

    // Returns {Q, not_Q} for an invalid command given the current Q.
    function automatic logic [1:0] invalid_outcome(input logic q_cur);
        logic [1:0] res;
        case (INVALID_POLICY)
            1:       res = {q_cur, ~q_cur};
            2:       res = 2'b10;
            3:       res = 2'b01;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] nq_next;
    logic [WIDTH-1:0] inv_next;
    logic             sticky_next;

    always_comb begin
        q_next   = Q;
        nq_next  = not_Q;
        inv_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // A hold regenerates not_Q from Q. Outside policy 0 this is a
            // no-op; after a policy-0 invalid (Q=not_Q=0) it resolves the
            // pair to Q=0, not_Q=1. S/R are only looked at under EN=1, so an
            // unknown S/R on a gated-off bit never reaches the outputs.
            q_next[i]  = Q[i];
            nq_next[i] = ~Q[i];
            if (EN[i] == 1'b1) begin
                case ({S[i], R[i]})
                    2'b01: begin
                        q_next[i]  = 1'b0;
                        nq_next[i] = 1'b1;
                    end
                    2'b10: begin
                        q_next[i]  = 1'b1;
                        nq_next[i] = 1'b0;
                    end
                    2'b11: begin
                        inv_next[i] = 1'b1;
                        {q_next[i], nq_next[i]} = invalid_outcome(Q[i]);
                    end
                    default: begin
                        q_next[i]  = Q[i];
                        nq_next[i] = ~Q[i];
                    end
                endcase
            end
        end
    end

    // A new invalid event beats a simultaneous clear.
    always_comb begin
        if (|inv_next) begin
            sticky_next = 1'b1;
        end else if (err_clr) begin
            sticky_next = 1'b0;
        end else begin
            sticky_next = err_sticky;
        end
    end

    // Output register stage: one clock of latency from sampled inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q          <= '0;
            not_Q      <= '1;
            invalid    <= '0;
            err_sticky <= 1'b0;
        end else begin
            Q          <= q_next;
            not_Q      <= nq_next;
            invalid    <= inv_next;
            err_sticky <= sticky_next;
        end
    end

endmodule

// File: tb/tb_sr_latch_sync.sv
// ============================================================================
// tb_sr_latch_sync
// ----------------------------------------------------------------------------
// Four WIDTH=1 instances (policies 0..3) share one 1-bit stimulus stream; a
// WIDTH=4 policy-0 instance gets its own vector stream. rst_n and err_clr are
// common. Every vector carries hand-computed expected outputs, queued by the
// driver and checked by an independent monitor after each rising edge.
// ============================================================================
module tb_sr_latch_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       err_clr;
    logic       en1, s1, r1;
    logic [3:0] en4, s4, r4;

    wire  [3:0] q1, nq1, inv1, st1;
    wire  [3:0] q4, nq4, inv4;
    wire        st4;

    for (genvar p = 0; p < 4; p++) begin : g_pol
        sr_latch_sync #(.WIDTH(1), .INVALID_POLICY(p)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .EN         (en1),
            .S          (s1),
            .R          (r1),
            .Q          (q1[p:p]),
            .not_Q      (nq1[p:p]),
            .invalid    (inv1[p:p]),
            .err_clr    (err_clr),
            .err_sticky (st1[p])
        );
    end

    sr_latch_sync #(.WIDTH(4), .INVALID_POLICY(0)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .EN         (en4),
        .S          (s4),
        .R          (r4),
        .Q          (q4),
        .not_Q      (nq4),
        .invalid    (inv4),
        .err_clr    (err_clr),
        .err_sticky (st4)
    );

    typedef struct {
        string      name;
        logic [3:0] q, nq;      // 1-bit instances, bit p = policy p
        logic       inv, st;    // identical across policies
        logic [3:0] q4, nq4, inv4;
        logic       st4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input string field,
                       input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %b, expected %b", nm, field, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic rn, input logic clr,
                        input logic en, input logic s, input logic r,
                        input logic [3:0] e4, input logic [3:0] ss4,
                        input logic [3:0] rr4,
                        input logic [3:0] eq, input logic [3:0] enq,
                        input logic ei, input logic est,
                        input logic [3:0] eq4, input logic [3:0] enq4,
                        input logic [3:0] ei4, input logic est4);
        exp_t e;
        @(negedge clk);
        rst_n   = rn;
        err_clr = clr;
        en1 = en; s1 = s; r1 = r;
        en4 = e4; s4 = ss4; r4 = rr4;
        e.name = nm;
        e.q = eq; e.nq = enq; e.inv = ei; e.st = est;
        e.q4 = eq4; e.nq4 = enq4; e.inv4 = ei4; e.st4 = est4;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid one edge after the vector was applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "Q",       q1,   e.q);
                chk(e.name, "not_Q",   nq1,  e.nq);
                chk(e.name, "invalid", inv1, {4{e.inv}});
                chk(e.name, "sticky",  st1,  {4{e.st}});
                chk(e.name, "Q4",      q4,   e.q4);
                chk(e.name, "not_Q4",  nq4,  e.nq4);
                chk(e.name, "inv4",    inv4, e.inv4);
                chk(e.name, "sticky4", {3'b000, st4}, {3'b000, e.st4});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic X = 1'bx;
    localparam logic [3:0] XX = 4'bxxxx;

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        en1 = 1'b0; s1 = 1'b0; r1 = 1'b0;
        en4 = '0; s4 = '0; r4 = '0;

        //     name         rn clr en s  r   en4      s4       r4       Q        nQ       inv st  Q4       nQ4      inv4     st4
        step("reset0",      0, 0, 0, X, X, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        step("reset1",      0, 0, 0, X, X, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        step("release",     1, 0, 0, X, X, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        step("en_hold",     1, 0, 1, 0, 0, 4'b1111, 4'b1000, 4'b0111, 4'b0000, 4'b1111, 0, 0, 4'b1000, 4'b0111, 4'b0000, 0);
        step("reset_cmd",   1, 0, 1, 0, 1, 4'b1111, 4'b0101, 4'b0011, 4'b0000, 4'b1111, 0, 0, 4'b1100, 4'b0010, 4'b0001, 1);
        step("set_cmd",     1, 0, 1, 1, 0, 4'b0000, XX,      XX,      4'b1111, 4'b0000, 0, 0, 4'b1100, 4'b0011, 4'b0000, 1);
        step("set_hold",    1, 0, 1, 0, 0, 4'b0000, XX,      XX,      4'b1111, 4'b0000, 0, 0, 4'b1100, 4'b0011, 4'b0000, 1);
        step("gate_hold",   1, 0, 0, X, X, 4'b0000, XX,      XX,      4'b1111, 4'b0000, 0, 0, 4'b1100, 4'b0011, 4'b0000, 1);
        step("inv_from1",   1, 0, 1, 1, 1, 4'b1010, 4'b0010, 4'b1000, 4'b0110, 4'b1000, 1, 1, 4'b0110, 4'b1001, 4'b0000, 1);
        step("recover",     1, 0, 1, 0, 0, 4'b0000, XX,      XX,      4'b0110, 4'b1001, 0, 1, 4'b0110, 4'b1001, 4'b0000, 1);
        step("clr",         1, 1, 1, 0, 0, 4'b0000, XX,      XX,      4'b0110, 4'b1001, 0, 0, 4'b0110, 4'b1001, 4'b0000, 0);
        step("clr_and_inv", 1, 1, 1, 1, 1, 4'b0100, 4'b1111, 4'b0100, 4'b0110, 4'b1000, 1, 1, 4'b0010, 4'b1001, 4'b0100, 1);
        step("gate_recov",  1, 0, 0, X, X, 4'b0000, XX,      XX,      4'b0110, 4'b1001, 0, 1, 4'b0010, 4'b1101, 4'b0000, 1);
        step("set2",        1, 0, 1, 1, 0, 4'b0000, XX,      XX,      4'b1111, 4'b0000, 0, 1, 4'b0010, 4'b1101, 4'b0000, 1);
        step("reset2",      1, 0, 1, 0, 1, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 1, 4'b0010, 4'b1101, 4'b0000, 1);
        step("inv_from0",   1, 0, 1, 1, 1, 4'b0000, XX,      XX,      4'b0100, 4'b1010, 1, 1, 4'b0010, 4'b1101, 4'b0000, 1);
        step("reset_after", 1, 0, 1, 0, 1, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 1, 4'b0010, 4'b1101, 4'b0000, 1);
        step("mid_reset",   0, 0, 1, 1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        step("post_reset",  1, 0, 1, 0, 0, 4'b0000, XX,      XX,      4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);

        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
